// File: rtl/ga_pkg.sv
// rtl/ga_pkg.sv - shared types, widths and seed helpers for the ga campaign controller
package ga_pkg;

    localparam logic [31:0] SEED_STEP_DEFAULT = 32'h9E3779B9;

    typedef enum logic [2:0] {
        IDLE,
        RST,
        RUN,
        CAPTURE,
        NEXT
    } run_ctrl_state_t;

    function automatic int fitness_width(input int chrom_width);
        return (chrom_width + 1) * 3;
    endfunction

    // The ga rng locks up on an all-zero seed, so zero is replaced by one.
    function automatic logic [31:0] nonzero_seed(input logic [31:0] s);
        return (s == 32'h0) ? 32'h1 : s;
    endfunction

endpackage

// File: rtl/ga_seed_gen.sv
// rtl/ga_seed_gen.sv - per-run seed register: load, additive step, zero substitution
module ga_seed_gen
    import ga_pkg::*;
#(
    parameter logic [31:0] SEED_STEP = SEED_STEP_DEFAULT
) (
    input  logic        clk,         // clock
    input  logic        reset,       // synchronous, active-high
    input  logic        load,        // load load_value as the raw seed
    input  logic [31:0] load_value,  // seed of run 0
    input  logic        step,        // advance raw seed by SEED_STEP
    output logic [31:0] seed         // effective (never zero once loaded) seed
);

    // The raw sequence is kept separately so that substituting 1 for 0 does
    // not shift the seeds of the following runs.
    logic [31:0] raw;
    logic [31:0] raw_next;

    always_comb begin
        raw_next = raw;
        if (load) begin
            raw_next = load_value;
        end else if (step) begin
            raw_next = raw + SEED_STEP;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            raw  <= 32'h0;
            seed <= 32'h0;
        end else if (load || step) begin
            raw  <= raw_next;
            seed <= nonzero_seed(raw_next);
        end
    end

endmodule

// File: rtl/ga_run_ctrl.sv
// rtl/ga_run_ctrl.sv - runs the ga core RUNS times with distinct seeds and keeps the overall best
module ga_run_ctrl
    import ga_pkg::*;
#(
    parameter int          CHROM_WIDTH   = 16,
    parameter int          FITNESS_WIDTH = fitness_width(CHROM_WIDTH),
    parameter int          RUNS          = 8,
    parameter int          RESET_CYCLES  = 4,
    parameter int          TIMEOUT       = 65535,
    parameter logic [31:0] SEED_STEP     = SEED_STEP_DEFAULT,
    localparam int         RUN_W         = (RUNS > 1) ? $clog2(RUNS) : 1
) (
    input  logic                     clk,          // clock
    input  logic                     reset,        // synchronous, active-high
    input  logic                     start,        // campaign start pulse, ignored while busy
    input  logic [31:0]              base_seed,    // seed of run 0
    output logic                     ga_reset,     // reset to ga core
    output logic [31:0]              ga_seed,      // seed to ga core
    input  logic [CHROM_WIDTH-1:0]   ga_best,      // ga best chromosome
    input  logic [FITNESS_WIDTH-1:0] ga_best_fit,  // ga best fitness
    input  logic                     ga_finished,  // ga run complete (level)
    output logic                     busy,         // campaign in progress
    output logic                     done,         // campaign complete, held
    output logic                     run_valid,    // one pulse per completed run
    output logic [CHROM_WIDTH-1:0]   best,         // overall best chromosome
    output logic [FITNESS_WIDTH-1:0] best_fit,     // overall best fitness
    output logic [RUN_W-1:0]         best_run,     // run that produced best
    output logic [RUN_W:0]           timeouts      // runs abandoned by timeout
);

    localparam int TMO_W = $clog2(TIMEOUT);
    localparam int RST_W = $clog2(RESET_CYCLES);

    run_ctrl_state_t state;
    run_ctrl_state_t state_next;

    logic [RUN_W-1:0] run_idx;
    logic [TMO_W-1:0] tmo_cnt;
    logic [RST_W-1:0] rst_cnt;

    logic rst_done;
    logic tmo_hit;
    logic last_run;
    logic accept;

    assign rst_done = (rst_cnt == RST_W'(RESET_CYCLES - 1));
    assign tmo_hit  = (tmo_cnt == TMO_W'(TIMEOUT - 1));
    assign last_run = (run_idx == RUN_W'(RUNS - 1));
    assign accept   = (state == IDLE) && start;

    ga_seed_gen #(
        .SEED_STEP (SEED_STEP)
    ) u_seed_gen (
        .clk        (clk),
        .reset      (reset),
        .load       (accept),
        .load_value (base_seed),
        .step       ((state == NEXT) && !last_run),
        .seed       (ga_seed)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A finish seen on the last timeout cycle still wins over the timeout.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RST;
            RST:     if (rst_done) state_next = RUN;
            RUN: begin
                if (ga_finished) begin
                    state_next = CAPTURE;
                end else if (tmo_hit) begin
                    state_next = NEXT;
                end
            end
            CAPTURE: state_next = NEXT;
            NEXT:    state_next = last_run ? IDLE : RST;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ga_reset  <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            run_valid <= 1'b0;
            best      <= '0;
            best_fit  <= '0;
            best_run  <= '0;
            timeouts  <= '0;
            run_idx   <= '0;
            tmo_cnt   <= '0;
            rst_cnt   <= '0;
        end else begin
            // The ga is only released while running or being captured, so
            // ga_reset rises in NEXT, two cycles after ga_finished.
            ga_reset  <= !((state_next == RUN) || (state_next == CAPTURE));
            run_valid <= (state == RUN) && ga_finished;
            case (state)
                IDLE: begin
                    if (start) begin
                        best     <= '0;
                        best_fit <= '0;
                        best_run <= '0;
                        timeouts <= '0;
                        done     <= 1'b0;
                        busy     <= 1'b1;
                        run_idx  <= '0;
                        rst_cnt  <= '0;
                    end
                end
                RST: begin
                    if (rst_done) begin
                        rst_cnt <= '0;
                        tmo_cnt <= '0;
                    end else begin
                        rst_cnt <= rst_cnt + RST_W'(1);
                    end
                end
                RUN: begin
                    tmo_cnt <= tmo_cnt + TMO_W'(1);
                    if (!ga_finished && tmo_hit) begin
                        timeouts <= timeouts + (RUN_W + 1)'(1);
                    end
                end
                CAPTURE: begin
                    // Strict compare: ties keep the earlier run.
                    if ((run_idx == '0) || (ga_best_fit > best_fit)) begin
                        best     <= ga_best;
                        best_fit <= ga_best_fit;
                        best_run <= run_idx;
                    end
                end
                NEXT: begin
                    if (last_run) begin
                        busy <= 1'b0;
                        done <= 1'b1;
                    end else begin
                        run_idx <= run_idx + RUN_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ga_run_ctrl.sv
// tb/tb_ga_run_ctrl.sv - self-checking bench for ga_run_ctrl with a behavioural ga stub
module tb_ga_run_ctrl;
    import ga_pkg::*;

    localparam int          CW   = 16;
    localparam int          FW   = fitness_width(CW);
    localparam int          RUNS = 4;
    localparam int          RW   = 2;
    localparam int          RC   = 4;
    localparam int          TMO  = 120;
    localparam logic [31:0] STEP = 32'h9E3779B9;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [31:0]   base_seed = 32'h0;
    logic          ga_reset;
    logic [31:0]   ga_seed;
    logic [CW-1:0] ga_best;
    logic [FW-1:0] ga_best_fit;
    logic          ga_finished;
    logic          busy;
    logic          done;
    logic          run_valid;
    logic [CW-1:0] best;
    logic [FW-1:0] best_fit;
    logic [RW-1:0] best_run;
    logic [RW:0]   timeouts;

    always #5 clk = ~clk;

    ga_run_ctrl #(
        .CHROM_WIDTH   (CW),
        .FITNESS_WIDTH (FW),
        .RUNS          (RUNS),
        .RESET_CYCLES  (RC),
        .TIMEOUT       (TMO),
        .SEED_STEP     (STEP)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .base_seed   (base_seed),
        .ga_reset    (ga_reset),
        .ga_seed     (ga_seed),
        .ga_best     (ga_best),
        .ga_best_fit (ga_best_fit),
        .ga_finished (ga_finished),
        .busy        (busy),
        .done        (done),
        .run_valid   (run_valid),
        .best        (best),
        .best_fit    (best_fit),
        .best_run    (best_run),
        .timeouts    (timeouts)
    );

    // ga stub: finishes on released cycle st_delay[run] (0-based), results per run.
    int            st_delay [RUNS];
    logic [CW-1:0] st_chrom [RUNS];
    logic [FW-1:0] st_fit   [RUNS];
    int            stub_cnt  = 0;
    int            stub_run  = 0;
    logic          stub_prev = 1'b1;

    always @(posedge clk) begin
        if (reset || (start && !busy)) begin
            stub_run <= 0;
        end else if (ga_reset && !stub_prev && stub_run < RUNS - 1) begin
            stub_run <= stub_run + 1;
        end
        stub_prev <= ga_reset;
        stub_cnt  <= ga_reset ? 0 : stub_cnt + 1;
    end

    assign ga_finished = !ga_reset && (stub_cnt >= st_delay[stub_run]);
    assign ga_best     = st_chrom[stub_run];
    assign ga_best_fit = st_fit[stub_run];

    typedef struct {
        logic          ga_reset;
        logic [31:0]   ga_seed;
        logic          busy;
        logic          done;
        logic          run_valid;
        logic [CW-1:0] best;
        logic [FW-1:0] best_fit;
        logic [RW-1:0] best_run;
        logic [RW:0]   timeouts;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        idle_exp;
    exp_t        cur;
    int          errors = 0;
    int          checks = 0;
    int          rv_count = 0;
    logic [31:0] seen_seed[$];
    int          low_len[$];
    int          low_run = 0;
    logic        prev_ga_reset = 1'b1;

    function automatic exp_t reset_exp();
        exp_t e;
        e.ga_reset  = 1'b1;
        e.ga_seed   = 32'h0;
        e.busy      = 1'b0;
        e.done      = 1'b0;
        e.run_valid = 1'b0;
        e.best      = '0;
        e.best_fit  = '0;
        e.best_run  = '0;
        e.timeouts  = '0;
        return e;
    endfunction

    // Expected cycle-by-cycle view of one campaign, starting the cycle after acceptance.
    task automatic plan_campaign(input logic [31:0] base);
        exp_t        e;
        logic [31:0] raw;
        e = reset_exp();
        e.busy = 1'b1;
        raw = base;
        for (int r = 0; r < RUNS; r++) begin
            e.ga_seed  = (raw == 32'h0) ? 32'h1 : raw;
            e.ga_reset = 1'b1;
            repeat (RC) exp_q.push_back(e);
            e.ga_reset = 1'b0;
            if (st_delay[r] < TMO) begin
                repeat (st_delay[r] + 1) exp_q.push_back(e);
                e.run_valid = 1'b1;
                exp_q.push_back(e);
                e.run_valid = 1'b0;
                if (r == 0 || st_fit[r] > e.best_fit) begin
                    e.best     = st_chrom[r];
                    e.best_fit = st_fit[r];
                    e.best_run = RW'(r);
                end
            end else begin
                repeat (TMO) exp_q.push_back(e);
                e.timeouts = e.timeouts + (RW + 1)'(1);
            end
            e.ga_reset = 1'b1;
            exp_q.push_back(e);
            raw = raw + STEP;
        end
        e.busy = 1'b0;
        e.done = 1'b1;
        exp_q.push_back(e);
    endtask

    task automatic model_cycle();
        if (exp_q.size() > 0) begin
            cur = exp_q.pop_front();
            idle_exp = cur;
        end else begin
            cur = idle_exp;
        end
        checks++;
        if (ga_reset !== cur.ga_reset || ga_seed !== cur.ga_seed || busy !== cur.busy ||
            done !== cur.done || run_valid !== cur.run_valid || best !== cur.best ||
            best_fit !== cur.best_fit || best_run !== cur.best_run || timeouts !== cur.timeouts) begin
            errors++;
            if (errors <= 20)
                $display("FAIL cycle_compare @%0t actual/required: ga_reset=%0b/%0b ga_seed=%h/%h busy=%0b/%0b done=%0b/%0b run_valid=%0b/%0b best=%h/%h best_fit=%0d/%0d best_run=%0d/%0d timeouts=%0d/%0d",
                         $time, ga_reset, cur.ga_reset, ga_seed, cur.ga_seed, busy, cur.busy,
                         done, cur.done, run_valid, cur.run_valid, best, cur.best,
                         best_fit, cur.best_fit, best_run, cur.best_run, timeouts, cur.timeouts);
        end
        if (run_valid === 1'b1) rv_count++;
        if (prev_ga_reset && !ga_reset) begin
            seen_seed.push_back(ga_seed);
            low_run = 0;
        end
        if (ga_reset === 1'b0) low_run++;
        if (!prev_ga_reset && ga_reset) low_len.push_back(low_run);
        prev_ga_reset = ga_reset;
        // Inputs seen now take effect at the coming edge.
        if (reset) begin
            exp_q.delete();
            idle_exp = reset_exp();
        end else if (start && exp_q.size() == 0) begin
            plan_campaign(base_seed);
        end
    endtask

    task automatic step();
        @(negedge clk);
        model_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic pulse_start(input logic [31:0] s);
        rv_count = 0;
        seen_seed.delete();
        low_len.delete();
        base_seed = s;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic drain(input bit poke);
        for (int i = 0; i < 3000 && exp_q.size() > 0; i++) begin
            start = poke && exp_q.size() > 1 && ($urandom_range(0, 49) == 0);
            base_seed = $urandom();
            step();
        end
        start = 1'b0;
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL campaign_drain: actual=%0d entries left required=0", exp_q.size());
        end
    endtask

    task automatic campaign(input logic [31:0] s, input bit poke);
        pulse_start(s);
        drain(poke);
    endtask

    task automatic set_runs(input int d0, input int d1, input int d2, input int d3,
                            input int f0, input int f1, input int f2, input int f3);
        st_delay[0] = d0; st_delay[1] = d1; st_delay[2] = d2; st_delay[3] = d3;
        st_fit[0] = FW'(f0); st_fit[1] = FW'(f1); st_fit[2] = FW'(f2); st_fit[3] = FW'(f3);
        for (int r = 0; r < RUNS; r++) st_chrom[r] = CW'(16'hA000 + r);
    endtask

    initial begin
        idle_exp = reset_exp();
        set_runs(5, 5, 5, 5, 0, 0, 0, 0);

        // reset state
        step();
        step();
        check_val("reset_ga_reset", 64'(ga_reset), 64'd1);
        check_val("reset_ga_seed", 64'(ga_seed), 64'd0);
        check_val("reset_busy", 64'(busy), 64'd0);
        check_val("reset_done", 64'(done), 64'd0);
        check_val("reset_timeouts", 64'(timeouts), 64'd0);
        reset = 1'b0;
        step();

        // 1: fits 5,9,9,3 -> tie keeps run 1
        set_runs(100, 100, 100, 100, 5, 9, 9, 3);
        campaign(32'h1000, 1'b0);
        check_val("t1_done", 64'(done), 64'd1);
        check_val("t1_busy", 64'(busy), 64'd0);
        check_val("t1_best_fit", 64'(best_fit), 64'd9);
        check_val("t1_best_run", 64'(best_run), 64'd1);
        check_val("t1_best", 64'(best), 64'hA001);
        check_val("t1_timeouts", 64'(timeouts), 64'd0);
        check_val("t1_run_valid_pulses", 64'(rv_count), 64'd4);
        check_val("t1_seed0", 64'(seen_seed[0]), 64'h1000);
        check_val("t1_seed1", 64'(seen_seed[1]), 64'h9E3789B9);

        // 2: second seed wraps to zero and is substituted
        set_runs(10, 10, 10, 10, 1, 2, 3, 4);
        campaign(32'h61C88647, 1'b0);
        check_val("t2_seed0", 64'(seen_seed[0]), 64'h61C88647);
        check_val("t2_seed1_subst", 64'(seen_seed[1]), 64'h1);
        check_val("t2_seed2", 64'(seen_seed[2]), 64'h9E3779B9);

        // 3: run 1 never finishes
        set_runs(20, 1000, 30, 40, 4, 99, 7, 2);
        campaign(32'h2222, 1'b0);
        check_val("t3_timeouts", 64'(timeouts), 64'd1);
        check_val("t3_run_valid_pulses", 64'(rv_count), 64'd3);
        check_val("t3_best_fit", 64'(best_fit), 64'd7);
        check_val("t3_best_run", 64'(best_run), 64'd2);
        check_val("t3_run0_released", 64'(low_len[0]), 64'd22);
        check_val("t3_run1_released", 64'(low_len[1]), 64'(TMO));

        // 4: finish on the last timeout cycle wins; one cycle later is a timeout
        set_runs(TMO - 1, TMO, 3, 3, 6, 50, 6, 2);
        campaign(32'h3333, 1'b0);
        check_val("t4_timeouts", 64'(timeouts), 64'd1);
        check_val("t4_run_valid_pulses", 64'(rv_count), 64'd3);
        check_val("t4_best_run_tie", 64'(best_run), 64'd0);
        check_val("t4_run0_released", 64'(low_len[0]), 64'(TMO + 1));

        // all runs time out
        set_runs(1000, 1000, 1000, 1000, 9, 9, 9, 9);
        campaign(32'h4444, 1'b0);
        check_val("tall_done", 64'(done), 64'd1);
        check_val("tall_timeouts", 64'(timeouts), 64'(RUNS));
        check_val("tall_best_fit", 64'(best_fit), 64'd0);
        check_val("tall_best", 64'(best), 64'd0);

        // 5: reset during RUN of run 2, then a fresh campaign
        set_runs(50, 50, 50, 50, 3, 8, 2, 8);
        pulse_start(32'h5555);
        for (int i = 0; i < 2000 && seen_seed.size() < 3; i++) step();
        check_val("t5_reached_run2", 64'(seen_seed.size()), 64'd3);
        repeat (5) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_val("t5_ga_reset", 64'(ga_reset), 64'd1);
        check_val("t5_busy", 64'(busy), 64'd0);
        check_val("t5_best_fit", 64'(best_fit), 64'd0);
        check_val("t5_ga_seed", 64'(ga_seed), 64'd0);
        step();
        campaign(32'h5556, 1'b0);
        check_val("t5_done", 64'(done), 64'd1);
        check_val("t5_best_run", 64'(best_run), 64'd1);
        check_val("t5_run_valid_pulses", 64'(rv_count), 64'd4);

        // 6: start during RUN ignored; start with reset ignored
        set_runs(30, 30, 30, 30, 1, 1, 1, 1);
        pulse_start(32'h6000);
        for (int i = 0; i < 500 && seen_seed.size() < 1; i++) step();
        repeat (3) step();
        base_seed = 32'hDEAD;
        start = 1'b1;
        step();
        start = 1'b0;
        drain(1'b0);
        check_val("t6_seed1", 64'(seen_seed[1]), 64'(32'h6000 + STEP));
        check_val("t6_run_valid_pulses", 64'(rv_count), 64'd4);
        reset = 1'b1;
        start = 1'b1;
        step();
        reset = 1'b0;
        start = 1'b0;
        check_val("t6_reset_wins_done", 64'(done), 64'd0);
        step();
        step();
        check_val("t6_not_started", 64'(busy), 64'd0);

        // randomized campaigns
        for (int k = 0; k < 8; k++) begin
            int exp_rv;
            exp_rv = 0;
            for (int r = 0; r < RUNS; r++) begin
                if ($urandom_range(0, 9) < 2) st_delay[r] = TMO - 1 + $urandom_range(0, 2);
                else st_delay[r] = $urandom_range(0, 60);
                if ($urandom_range(0, 3) == 0) st_fit[r] = FW'({$urandom(), $urandom()});
                else st_fit[r] = FW'($urandom_range(0, 7));
                st_chrom[r] = CW'($urandom());
                if (st_delay[r] < TMO) exp_rv++;
            end
            campaign((k == 3) ? (32'h0 - STEP * 2) : $urandom(), 1'b1);
            check_val("rand_run_valid_pulses", 64'(rv_count), 64'(exp_rv));
            repeat ($urandom_range(0, 3)) step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
